// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter between the MEM stage and a debug/loader port.
// CPU wins by default; wait_cnt bounds debug starvation, burst_cnt bounds CPU starvation.
module dmem_arbiter #(
  parameter  int ADDR_W    = 8,
  parameter  int DATA_W    = 32,
  parameter  int MAX_WAIT  = 4,
  parameter  int MAX_BURST = 8,
  localparam int WAIT_W    = $clog2(MAX_WAIT + 1),
  localparam int BURST_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_burst,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fsm_dbg_own,
  output logic [WAIT_W-1:0] fsm_wait_cnt
);

  typedef enum logic {CPU_OWN = 1'b0, DBG_OWN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_owner_q, rd_owner_d;
  logic                 cpu_grant;

  // Handshake: dbg_req (with its fields) is held until dbg_gnt; an access is
  // consumed on every cycle its grant is high. cpu_req is held while cpu_stall.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    dbg_gnt     = 1'b0;
    cpu_grant   = 1'b0;
    if (rst) begin
      unique case (state_q)
        CPU_OWN: begin
          dbg_gnt   = dbg_req && (!cpu_req || wait_cnt_q == WAIT_W'(MAX_WAIT));
          cpu_grant = cpu_req && !dbg_gnt;
          if (dbg_gnt && dbg_burst && (MAX_BURST > 1)) begin
            state_d     = DBG_OWN;
            burst_cnt_d = BURST_W'(1);
          end
        end
        DBG_OWN: begin
          // The exit cycle itself is still granted when dbg_req is high.
          dbg_gnt = dbg_req;
          if (!dbg_req || !dbg_burst || burst_cnt_q == BURST_W'(MAX_BURST - 1)) begin
            state_d     = CPU_OWN;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
          end
        end
        default: state_d = CPU_OWN;
      endcase
    end
    cpu_stall = rst && cpu_req && !cpu_grant;

    if (dbg_req && !dbg_gnt) begin
      wait_cnt_d = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end else begin
      wait_cnt_d = '0;
    end

    mem_en    = dbg_gnt || cpu_grant;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_grant) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end

    rd_valid_d = mem_en && !mem_we;
    rd_owner_d = rd_valid_d ? dbg_gnt : rd_owner_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= CPU_OWN;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_owner_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  // rvalid is gated by rst so a read issued just before reset never returns.
  assign cpu_rvalid   = rst && rd_valid_q && !rd_owner_q;
  assign dbg_rvalid   = rst && rd_valid_q && rd_owner_q;
  assign cpu_rdata    = mem_rdata;
  assign dbg_rdata    = mem_rdata;
  assign fsm_dbg_own  = (state_q == DBG_OWN);
  assign fsm_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a bench-side RAM, a per-cycle reference model
// of the arbitration rules, and literal checks for each scenario.
module tb_dmem_arbiter;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dbg_req, dbg_burst, dbg_we, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              fsm_dbg_own;
  logic [2:0]        fsm_wait_cnt;

  logic [DATA_W-1:0] ram       [256];
  logic [DATA_W-1:0] model_mem [256];

  int n_chk  = 0;
  int n_fail = 0;
  logic checking = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_burst(dbg_burst), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fsm_dbg_own(fsm_dbg_own), .fsm_wait_cnt(fsm_wait_cnt)
  );

  // Bench-side synchronous RAM driven by the DUT's mem_* outputs.
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  int                m_own   = 0;  // 1 while debug holds the bus for a burst
  int                m_wait  = 0;  // consecutive refused debug-request cycles
  int                m_burst = 0;  // debug grants taken in the current burst
  int                m_rd    = 0;  // 0 none, 1 cpu, 2 dbg read returning
  logic [DATA_W-1:0] m_rd_data = '0;

  always @(negedge clk) begin : model_chk
    logic              e_dg, e_cg, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    if (checking) begin
      if (!rst) begin
        e_dg = 1'b0; e_cg = 1'b0;
      end else if (m_own != 0) begin
        e_dg = dbg_req; e_cg = 1'b0;
      end else begin
        e_dg = dbg_req && (!cpu_req || m_wait >= MAX_WAIT);
        e_cg = cpu_req && !e_dg;
      end
      e_we   = e_dg ? dbg_we    : (e_cg ? cpu_we    : 1'b0);
      e_addr = e_dg ? dbg_addr  : (e_cg ? cpu_addr  : '0);
      e_wd   = e_dg ? dbg_wdata : (e_cg ? cpu_wdata : '0);

      chk("m_dbg_gnt",   32'(dbg_gnt),    32'(e_dg));
      chk("m_cpu_stall", 32'(cpu_stall),  32'(rst && cpu_req && !e_cg));
      chk("m_mem_en",    32'(mem_en),     32'(e_dg || e_cg));
      chk("m_mem_we",    32'(mem_we),     32'(e_we));
      chk("m_mem_addr",  32'(mem_addr),   32'(e_addr));
      chk("m_mem_wdata", mem_wdata,       e_wd);
      chk("m_cpu_rvalid", 32'(cpu_rvalid), 32'(rst && m_rd == 1));
      chk("m_dbg_rvalid", 32'(dbg_rvalid), 32'(rst && m_rd == 2));
      if (rst && m_rd == 1) chk("m_cpu_rdata", cpu_rdata, m_rd_data);
      if (rst && m_rd == 2) chk("m_dbg_rdata", dbg_rdata, m_rd_data);
      chk("m_state",    32'(fsm_dbg_own),  32'(m_own));
      chk("m_wait_cnt", 32'(fsm_wait_cnt), 32'(m_wait));

      if (!rst) begin
        m_own = 0; m_wait = 0; m_burst = 0; m_rd = 0;
      end else begin
        m_rd = 0;
        if (e_dg || e_cg) begin
          if (e_we) model_mem[e_addr] = e_wd;
          else begin
            m_rd      = e_dg ? 2 : 1;
            m_rd_data = model_mem[e_addr];
          end
        end
        m_wait = (dbg_req && !e_dg) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
        if (m_own == 0) begin
          if (e_dg && dbg_burst && MAX_BURST > 1) begin
            m_own = 1; m_burst = 1;
          end
        end else begin
          if (e_dg) m_burst++;
          if (!dbg_req || !dbg_burst || m_burst >= MAX_BURST) begin
            m_own = 0; m_burst = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_burst = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  // ---------------- directed stimulus ----------------
  logic g [16];
  logic s [16];
  logic o [16];

  initial begin
    int first, run, stalls, early;
    for (int i = 0; i < 256; i++) begin
      ram[i]       = 32'h1000_0000 + 32'(i) * 32'h101;
      model_mem[i] = 32'h1000_0000 + 32'(i) * 32'h101;
    end
    idle_inputs();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_addr = 8'h23;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h44; dbg_wdata = 32'h0BAD_0BAD;

    // Reset held for two cycles with both requests high.
    next_cycle();
    checking = 1'b1;
    @(negedge clk);
    chk("rst_mem_en",     32'(mem_en),     32'd0);
    chk("rst_cpu_stall",  32'(cpu_stall),  32'd0);
    chk("rst_dbg_gnt",    32'(dbg_gnt),    32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);

    next_cycle();
    rst = 1'b1; dbg_req = 1'b0;
    @(negedge clk);
    chk("rd23_mem_addr", 32'(mem_addr), 32'h23);
    chk("rd23_mem_en",   32'(mem_en),   32'd1);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rd23_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd23_cpu_rdata",  cpu_rdata,       32'h1000_2323);

    // Contention: CPU reads continuously, debug write raised at T.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h10; dbg_wdata = 32'hDEAD_BEEF; dbg_burst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      g[k] = dbg_gnt; s[k] = cpu_stall;
      if (k < 4) next_cycle();
    end
    early = 0;
    for (int k = 0; k < 4; k++) if (g[k] || s[k]) early++;
    chk("cont_cpu_first4", 32'(early), 32'd0);
    chk("cont_dbg_gnt_t4", 32'(g[4]),  32'd1);
    chk("cont_stall_t4",   32'(s[4]),  32'd1);
    next_cycle();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("cont_ram10", ram[8'h10], 32'hDEAD_BEEF);

    // Burst cap with CPU pressure.
    next_cycle();
    cpu_addr = 8'h41;
    dbg_req = 1'b1; dbg_burst = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h80; dbg_wdata = 32'h55AA_0001;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      g[k] = dbg_gnt; s[k] = cpu_stall; o[k] = fsm_dbg_own;
      if (k < 13) next_cycle();
    end
    first = -1; run = 0; stalls = 0;
    for (int k = 0; k < 14; k++) if (first < 0 && g[k]) first = k;
    if (first >= 0) begin
      for (int k = first; k < 14 && g[k]; k++) begin
        run++;
        if (s[k]) stalls++;
      end
    end
    chk("burst_first_gnt", 32'(first),  32'd4);
    chk("burst_len",       32'(run),    32'd8);
    chk("burst_stalls",    32'(stalls), 32'd8);
    chk("burst_9th_gnt",   32'(g[12]),  32'd0);
    chk("burst_9th_stall", 32'(s[12]),  32'd0);
    chk("burst_9th_state", 32'(o[12]),  32'd0);

    // Read routing: debug read then CPU read on consecutive cycles.
    next_cycle();
    cpu_req = 1'b0; dbg_burst = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h05;
    @(negedge clk);
    chk("rr_dbg_gnt", 32'(dbg_gnt), 32'd1);
    next_cycle();
    dbg_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h06;
    @(negedge clk);
    chk("rr_dbg_rvalid",  32'(dbg_rvalid), 32'd1);
    chk("rr_dbg_rdata",   dbg_rdata,       32'h1000_0505);
    chk("rr_cpu_rvalid0", 32'(cpu_rvalid), 32'd0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rr_cpu_rvalid",  32'(cpu_rvalid), 32'd1);
    chk("rr_cpu_rdata",   cpu_rdata,       32'h1000_0606);
    chk("rr_dbg_rvalid0", 32'(dbg_rvalid), 32'd0);

    // Reset in cycle 3 of a debug read burst.
    next_cycle();
    dbg_req = 1'b1; dbg_burst = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h30;
    @(negedge clk);
    chk("rmb_gnt1", 32'(dbg_gnt), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("rmb_state2", 32'(fsm_dbg_own), 32'd1);
    chk("rmb_gnt2",   32'(dbg_gnt),     32'd1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rmb_no_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rmb_gnt_rst",   32'(dbg_gnt),    32'd0);
    next_cycle();
    rst = 1'b1; dbg_req = 1'b0; dbg_burst = 1'b0; cpu_req = 1'b1; cpu_addr = 8'h07;
    @(negedge clk);
    chk("rmb_state_post", 32'(fsm_dbg_own), 32'd0);
    chk("rmb_cpu_stall",  32'(cpu_stall),   32'd0);
    chk("rmb_cpu_mem_en", 32'(mem_en),      32'd1);
    chk("rmb_dbg_rv_post", 32'(dbg_rvalid), 32'd0);

    // Idle port: immediate debug grant, then an abandoned request.
    next_cycle();
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h90; dbg_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("idle_dbg_gnt", 32'(dbg_gnt), 32'd1);
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    dbg_addr = 8'h91; dbg_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("drop_wait_gnt0", 32'(dbg_gnt), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("drop_wait1", 32'(fsm_wait_cnt), 32'd1);
    next_cycle();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("drop_wait2", 32'(fsm_wait_cnt), 32'd2);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("drop_wait_clr", 32'(fsm_wait_cnt), 32'd0);
    chk("drop_no_write", ram[8'h91],        32'h1000_9191);
    chk("idle_ram90",    ram[8'h90],        32'h1234_5678);

    next_cycle();
    next_cycle();
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the pipeline's MEM stage and a debug/loader port. It sits between the MEM stage and the data RAM (one access per cycle, 1-cycle synchronous read). It grants the CPU by default and holds the pipeline with `cpu_stall` whenever the debug port owns the RAM. A wait counter bounds debug starvation, and a burst counter bounds CPU starvation.

## Interface
- `ADDR_W`, 8, word-address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 4, consecutive ungranted debug-request cycles before debug is forced in (≥1)
- `MAX_BURST`, 8, max consecutive debug grants in a burst (≥1)

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset
- `cpu_req`  in  1  MEM-stage access request
- `cpu_we`  in  1  1 = write
- `cpu_addr`  in  ADDR_W  word address
- `cpu_wdata`  in  DATA_W  write data
- `cpu_stall`  out  1  CPU request present but not granted this cycle
- `cpu_rvalid`  out  1  `cpu_rdata` valid (cycle after a granted CPU read)
- `cpu_rdata`  out  DATA_W  read data
- `dbg_req`  in  1  debug access request, held until granted
- `dbg_burst`  in  1  request bus ownership for consecutive cycles
- `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1 / ADDR_W / DATA_W  debug access fields
- `dbg_gnt`  out  1  debug access performed this cycle
- `dbg_rvalid`  out  1  `dbg_rdata` valid (cycle after a granted debug read)
- `dbg_rdata`  out  DATA_W  read data
- `mem_en`, `mem_we`  out  1 / 1  RAM enable and write strobe
- `mem_addr`, `mem_wdata`  out  ADDR_W / DATA_W  RAM address and write data
- `mem_rdata`  in  DATA_W  RAM read data, valid 1 cycle after `mem_en && !mem_we`

## Operation
- **FSM states:** `CPU_OWN` (reset state) and `DBG_OWN`.
- **Registered state:** `wait_cnt` (0..MAX_WAIT, saturating), `burst_cnt` (0..MAX_BURST-1), `rd_owner` (which requester issued the last read), `cpu_rvalid`, `dbg_rvalid`.
- **Grant decision in `CPU_OWN` (combinational):**
  - `dbg_gnt = dbg_req && (!cpu_req || wait_cnt == MAX_WAIT)`.
  - The CPU is granted when `cpu_req && !dbg_gnt`.
  - `cpu_stall = cpu_req && !cpu_grant`.
- **Grant decision in `DBG_OWN`:**
  - `dbg_gnt = dbg_req`.
  - `cpu_stall = cpu_req`.
- **RAM mux:**
  - The granted requester's `we`/`addr`/`wdata` drive the RAM.
  - `mem_en = 1` only when a grant is issued.
  - With no grant, `mem_we = 0` and addr/wdata are driven to 0.
- **`wait_cnt`:**
  - Increments (saturating) on cycles with `dbg_req && !dbg_gnt`.
  - Clears on `dbg_gnt` or `!dbg_req`.
- **`CPU_OWN` → `DBG_OWN`:** on `dbg_gnt && dbg_burst && MAX_BURST > 1`; `burst_cnt` is set to 1.
- **`DBG_OWN` → `CPU_OWN`:**
  - Exits when `!dbg_req`, `!dbg_burst`, or `burst_cnt == MAX_BURST-1`.
  - The cycle in which the exit condition holds is still granted if `dbg_req`.
  - Otherwise `burst_cnt` increments each granted cycle.
- **After a burst:** the first cycle back in `CPU_OWN` uses the normal rule with `wait_cnt = 0`, so a pending CPU request is served before debug.
- **Read return:**
  - A granted read registers `rd_owner` and raises that port's `rvalid` for exactly the next cycle.
  - `cpu_rdata` and `dbg_rdata` both pass `mem_rdata` through; each is qualified only by its own `rvalid`.
- **Writes:** produce no `rvalid`.

## Timing
- **Grant and stall latency:** combinational in the same cycle as the request; writes commit at the same edge.
- **Read latency:** 1 cycle from grant to `rvalid`, identical for both ports.
- **Back-to-back grants:** one per cycle, with no bubble on owner change.
- **Reset (`rst == 0` at an edge):**
  - State returns to `CPU_OWN`; `wait_cnt`, `burst_cnt`, `cpu_rvalid`, `dbg_rvalid` go to 0.
  - While `rst == 0`, `dbg_gnt`, `cpu_stall`, `mem_en`, and `mem_we` are forced to 0.
  - Reset mid-burst aborts the burst.
  - A read granted in the cycle before reset produces no `rvalid`.
- **Simultaneous requests:** with `wait_cnt < MAX_WAIT` the CPU wins. Debug worst-case wait is MAX_WAIT cycles; the grant lands on the (MAX_WAIT+1)-th request cycle.
- **CPU worst-case stall:** MAX_BURST consecutive cycles.
- **`dbg_req` dropping while ungranted:** clears `wait_cnt`; no access occurs.

## Test plan
- **Reset:** `rst = 0` for 2 cycles with both requests high -> `mem_en = cpu_stall = dbg_gnt = 0`, both `rvalid = 0`. After release, a CPU read of addr 0x23 -> `mem_addr = 0x23` and, next cycle, `cpu_rvalid = 1` with `cpu_rdata = RAM[0x23]`.
- **Contention:**
  - Stimulus: `cpu_req` held high; `dbg_req` write of 0xDEADBEEF to 0x10 raised at cycle T.
  - Response: CPU granted T..T+3, `dbg_gnt = 1` and `cpu_stall = 1` at T+4 (MAX_WAIT = 4), RAM[0x10] = 0xDEADBEEF after that edge.
- **Burst cap:**
  - Stimulus: `dbg_burst = 1` with `cpu_req` high.
  - Response: exactly 8 consecutive debug grants with the CPU stalled for those 8 cycles; CPU granted on the 9th; state `CPU_OWN`.
- **Read routing:**
  - Stimulus: debug read of 0x05 followed by a CPU read of 0x06 on consecutive cycles.
  - Response: `dbg_rvalid` with RAM[0x05] in the first return cycle, `cpu_rvalid` with RAM[0x06] in the next; never both high together.
- **Reset mid-burst:** in cycle 3 of a debug burst, assert `rst = 0` -> state returns to `CPU_OWN`, no `dbg_rvalid` for the read granted in the cycle before reset, and the first post-reset CPU request is granted immediately.
- **Idle port:** `dbg_req` alone with `cpu_req = 0` -> granted in the same cycle. `dbg_req` dropped after 2 waiting cycles -> `wait_cnt` back to 0 and no RAM write.
